ds_box_avg2x2: RTL

//   2:1 horizontal and vertical downscaler for the raw RGB video stream. Averages each
//   2x2 pixel block into one output pixel, using one half-width line buffer.

---
 rtl/ds_box_avg2x2.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ds_box_avg2x2.sv
// 2x2 box-average downscaler: each 2x2 block of input pixels becomes one output pixel.
// Even rows store horizontal pair sums in a half-width line buffer; odd rows complete the block.
module ds_box_avg2x2 #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned H_ACTIVE = 1920
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_r_data,
  input  logic [WIDTH-1:0] i_g_data,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [WIDTH-1:0] o_r_data,
  output logic [WIDTH-1:0] o_g_data,
  output logic [WIDTH-1:0] o_b_data
);

  localparam int unsigned CW    = $clog2(H_ACTIVE + 1);
  localparam int unsigned DEPTH = H_ACTIVE / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned SW    = WIDTH + 2;

  logic [CW-1:0]          r_col;
  logic                   r_row_odd;
  logic                   r_frame_ok;
  logic                   r_de_d;
  logic [2:0][WIDTH-1:0]  r_lat;
  logic [2:0][PW-1:0]     r_rd;
  logic [2:0][PW-1:0]     r_lbuf [DEPTH];

  logic                   w_vs_rise;
  logic                   w_de_fall;
  logic                   w_in_range;
  logic                   w_col_odd;
  logic                   w_lb_wr;
  logic                   w_lb_rd;
  logic                   w_emit;
  logic [AW-1:0]          w_addr;
  logic [2:0][WIDTH-1:0]  w_pix;
  logic [2:0][PW-1:0]     w_psum;
  logic [2:0][SW-1:0]     w_sum;
  logic [2:0][WIDTH-1:0]  w_avg;

  // o_vsync is the 1-cycle delayed input, so it doubles as the edge-detect history.
  assign w_vs_rise  = i_vsync & ~o_vsync;
  assign w_de_fall  = r_de_d & ~i_de;
  assign w_in_range = i_de && (r_col < CW'(H_ACTIVE)) && !w_vs_rise;
  assign w_col_odd  = r_col[0];
  assign w_addr     = AW'(r_col >> 1);
  assign w_lb_wr    = w_in_range & w_col_odd & ~r_row_odd;
  assign w_lb_rd    = w_in_range & ~w_col_odd & r_row_odd;
  assign w_emit     = w_in_range & w_col_odd & r_row_odd & r_frame_ok;

  always_comb begin
    w_pix[2] = i_r_data;
    w_pix[1] = i_g_data;
    w_pix[0] = i_b_data;
    for (int k = 0; k < 3; k++) begin
      w_psum[k] = {1'b0, r_lat[k]} + {1'b0, w_pix[k]};
      // WIDTH+2 bits hold 4*max+2 without wrap; +2 rounds half up.
      w_sum[k]  = {1'b0, r_rd[k]} + {1'b0, w_psum[k]} + SW'(2);
      w_avg[k]  = w_sum[k][SW-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_col      <= '0;
      r_row_odd  <= 1'b0;
      r_frame_ok <= 1'b0;
      r_de_d     <= 1'b0;
    end else begin
      r_de_d <= i_de;
      if (w_vs_rise) begin
        r_col      <= '0;
        r_row_odd  <= 1'b0;
        r_frame_ok <= 1'b1;
      end else begin
        if (!i_de) begin
          r_col <= '0;
        end else if (r_col != CW'(H_ACTIVE)) begin
          r_col <= r_col + CW'(1);
        end
        if (w_de_fall) begin
          r_row_odd <= ~r_row_odd;
        end
      end
    end
  end

  // Datapath storage needs no reset; contents are only consumed after being written.
  always_ff @(posedge clk) begin
    if (w_in_range && !w_col_odd) begin
      r_lat <= w_pix;
    end
    if (w_lb_wr) begin
      r_lbuf[w_addr] <= w_psum;
    end
    if (w_lb_rd) begin
      r_rd <= r_lbuf[w_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_vsync  <= 1'b0;
      o_hsync  <= 1'b0;
      o_de     <= 1'b0;
      o_r_data <= '0;
      o_g_data <= '0;
      o_b_data <= '0;
    end else begin
      o_vsync <= i_vsync;
      o_hsync <= i_hsync;
      o_de    <= w_emit;
      if (w_emit) begin
        o_r_data <= w_avg[2];
        o_g_data <= w_avg[1];
        o_b_data <= w_avg[0];
      end
    end
  end

endmodule
